reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL expose parameter SYNC_STAGES, default 2: flop depth of each synchronizer, legal 2..4.
REQ-002 SHALL expose parameter HOLD_CYCLES, default 16: cycles all outputs stay in reset after lock is seen, legal 1..255.
REQ-003 SHALL expose parameter NUM_OUT, default 3: number of sequenced reset outputs, legal 1..8.
REQ-004 SHALL expose parameter GAP_CYCLES, default 4: cycles between successive output releases, legal 1..255.
REQ-005 SHALL have port clk, input, 1: the only clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: asynchronous lock indication, synchronized internally.
REQ-008 SHALL have port ext_rst_req, input, 1: synchronous, active-high request to rerun the sequence.
REQ-009 SHALL have port rst_out, output, NUM_OUT: active-high downstream resets, bit 0 released first.
REQ-010 SHALL have port seq_done, output, 1: high while every rst_out bit is released.
REQ-011 SHALL have port restart_cnt, output, 8: count of restarts since rst_n, saturating at 255.

Function
REQ-012 SHALL derive the internal reset with async assertion on rst_n low and deassertion through SYNC_STAGES flops.
REQ-013 SHALL pass pll_locked through SYNC_STAGES flops, async-cleared by rst_n, giving lock_s.
REQ-014 SHALL implement the FSM states WAIT_LOCK, HOLD, RELEASE and DONE, with WAIT_LOCK as the reset state.
REQ-015 In WAIT_LOCK, the FSM SHALL move to HOLD on the first edge with lock_s=1, with its counter cleared.
REQ-016 In HOLD, the FSM SHALL count HOLD_CYCLES edges, then clear rst_out[0] and enter RELEASE on that edge.
REQ-017 In RELEASE, each rst_out[i] SHALL clear exactly GAP_CYCLES edges after rst_out[i-1], and bits SHALL never clear out of order.
REQ-018 On the edge that clears rst_out[NUM_OUT-1], the FSM SHALL enter DONE and set seq_done.
REQ-019 With NUM_OUT=1, the FSM SHALL set seq_done and enter DONE on the edge leaving HOLD.
REQ-020 If lock_s=0 in HOLD, RELEASE or DONE, the next edge SHALL set all rst_out bits, clear seq_done, enter WAIT_LOCK and increment restart_cnt.
REQ-021 If ext_rst_req=1 with lock_s=1 in RELEASE or DONE, the next edge SHALL set all rst_out bits, clear seq_done, enter HOLD with counter 0 and increment restart_cnt.
REQ-022 ext_rst_req in HOLD SHALL restart the hold count from 0 without incrementing restart_cnt; in WAIT_LOCK it SHALL be ignored.
REQ-023 When lock loss and ext_rst_req occur in the same cycle, lock loss SHALL win (WAIT_LOCK).
REQ-024 rst_out and seq_done SHALL be registered, glitch-free outputs.
REQ-025 restart_cnt SHALL hold at 255 and never wrap.

Reset
REQ-026 While rst_n=0, all outputs SHALL hold immediately, independent of clk: rst_out all ones, seq_done 0, restart_cnt 0, FSM in WAIT_LOCK, synchronizers 0.
REQ-027 rst_n asserted mid-sequence SHALL abort the sequence immediately and rerun it in full after release.

Verification (defaults; E1 = first rising edge after rst_n rises)
REQ-028 Bench SHALL check: pll_locked=1 throughout, rst_n rises -> FSM enters HOLD at E3; rst_out[0], rst_out[1] and rst_out[2] clear at E19, E23 and E27; seq_done=1 at E27.
REQ-029 Bench SHALL check: pll_locked=0 at power-up and rises 50 cycles later -> all rst_out stay 1 until HOLD_CYCLES after lock_s rises, then the sequence follows REQ-028 spacing.
REQ-030 Bench SHALL check: in DONE, pll_locked low for 5 cycles -> rst_out=3'b111 and seq_done=0 within SYNC_STAGES+1 edges, restart_cnt=1, full resequence after relock.
REQ-031 Bench SHALL check: ext_rst_req pulsed 1 cycle after rst_out[0] clears -> rst_out=3'b111 next edge, rst_out[0] clears 16 edges later, restart_cnt=1.
REQ-032 Bench SHALL check: rst_n pulsed low for 1 ns between clk edges during RELEASE -> rst_out=3'b111 at once, restart_cnt=0, sequence reruns as REQ-028.
REQ-033 Bench SHALL check: 300 ext_rst_req pulses, each issued in DONE -> restart_cnt saturates at 255.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for PLL lock, holds all resets, then
// releases rst_out bits one at a time, lowest first, with a fixed gap.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned NUM_OUT     = 3,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               ext_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               seq_done,
    output logic [7:0]         restart_cnt
);

    localparam int unsigned CNT_W     = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   sys_rst_n;
    logic                   lock_s;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_OUT-1:0]     rst_shl;
    logic [7:0]             restart_inc;

    // Internal reset: asserts with rst_n, releases after SYNC_STAGES edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sys_rst_n = rst_sync[SYNC_STAGES-1];

    // Lock synchronizer, cleared directly by the external reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];

    // Shifting left clears the lowest still-set bit, so release order is fixed
    assign rst_shl     = rst_out << 1;
    assign restart_inc = (restart_cnt == 8'hFF) ? restart_cnt : restart_cnt + 8'd1;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            rst_out     <= '1;
            seq_done    <= 1'b0;
            restart_cnt <= 8'd0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end

                HOLD: begin
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        rst_out     <= '1;
                        seq_done    <= 1'b0;
                        restart_cnt <= restart_inc;
                    end else if (ext_rst_req) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        rst_out <= rst_shl;
                        if (rst_shl == '0) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RELEASE: begin
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        rst_out     <= '1;
                        seq_done    <= 1'b0;
                        restart_cnt <= restart_inc;
                    end else if (ext_rst_req) begin
                        state       <= HOLD;
                        cnt         <= '0;
                        rst_out     <= '1;
                        seq_done    <= 1'b0;
                        restart_cnt <= restart_inc;
                    end else if (cnt == GAP_LAST) begin
                        cnt     <= '0;
                        rst_out <= rst_shl;
                        if (rst_shl == '0) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        rst_out     <= '1;
                        seq_done    <= 1'b0;
                        restart_cnt <= restart_inc;
                    end else if (ext_rst_req) begin
                        state       <= HOLD;
                        cnt         <= '0;
                        rst_out     <= '1;
                        seq_done    <= 1'b0;
                        restart_cnt <= restart_inc;
                    end
                end

                default: begin
                    state    <= WAIT_LOCK;
                    cnt      <= '0;
                    rst_out  <= '1;
                    seq_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters; a checkpoint
// table describes the nominal release timeline relative to the triggering edge.
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       ext_rst_req;
    logic [2:0] rst_out;
    logic       seq_done;
    logic [7:0] restart_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         edge_n;
        logic [2:0] rst;
        logic       done;
    } chk_t;

    chk_t seq_tbl [8];

    reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .NUM_OUT    (3),
        .GAP_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .ext_rst_req(ext_rst_req),
        .rst_out    (rst_out),
        .seq_done   (seq_done),
        .restart_cnt(restart_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string name, input logic [2:0] r, input logic d, input logic [7:0] c);
        chk({name, ".rst_out"}, 32'(rst_out), 32'(r));
        chk({name, ".seq_done"}, 32'(seq_done), 32'(d));
        chk({name, ".restart_cnt"}, 32'(restart_cnt), 32'(c));
    endtask

    // Walk the nominal timeline; edge 1 is the first rising edge after the trigger
    task automatic run_seq(input string name);
        int k;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            while (k < seq_tbl[i].edge_n) begin
                @(posedge clk);
                k++;
            end
            #1;
            chk($sformatf("%s.e%0d.rst_out", name, k), 32'(rst_out), 32'(seq_tbl[i].rst));
            chk($sformatf("%s.e%0d.seq_done", name, k), 32'(seq_done), 32'(seq_tbl[i].done));
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_cnt;
        int n;

        seq_tbl[0] = '{edge_n: 1,  rst: 3'b111, done: 1'b0};
        seq_tbl[1] = '{edge_n: 18, rst: 3'b111, done: 1'b0};
        seq_tbl[2] = '{edge_n: 19, rst: 3'b110, done: 1'b0};
        seq_tbl[3] = '{edge_n: 22, rst: 3'b110, done: 1'b0};
        seq_tbl[4] = '{edge_n: 23, rst: 3'b100, done: 1'b0};
        seq_tbl[5] = '{edge_n: 26, rst: 3'b100, done: 1'b0};
        seq_tbl[6] = '{edge_n: 27, rst: 3'b000, done: 1'b1};
        seq_tbl[7] = '{edge_n: 30, rst: 3'b000, done: 1'b1};

        rst_n       = 1'b0;
        pll_locked  = 1'b1;
        ext_rst_req = 1'b0;

        // Power-up with lock already present
        repeat (3) @(negedge clk);
        #1 chk_outs("reset", 3'b111, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("powerup");
        chk("powerup.restart_cnt", 32'(restart_cnt), 32'd0);

        // Lock loss in DONE, then relock
        @(negedge clk);
        pll_locked = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("lockloss.e2.rst_out", 32'(rst_out), 32'(3'b000));
        @(posedge clk);
        #1 chk_outs("lockloss.e3", 3'b111, 1'b0, 8'd1);
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        run_seq("relock");
        chk("relock.restart_cnt", 32'(restart_cnt), 32'd1);

        // ext_rst_req one cycle after rst_out[0] clears
        reset_pulse();
        repeat (19) @(posedge clk);
        #1 chk("ext.e19.rst_out", 32'(rst_out), 32'(3'b110));
        @(negedge clk);
        ext_rst_req = 1'b1;
        @(posedge clk);
        #1 chk_outs("ext.e20", 3'b111, 1'b0, 8'd1);
        @(negedge clk);
        ext_rst_req = 1'b0;
        repeat (15) @(posedge clk);
        #1 chk("ext.e35.rst_out", 32'(rst_out), 32'(3'b111));
        @(posedge clk);
        #1 chk_outs("ext.e36", 3'b110, 1'b0, 8'd1);
        repeat (8) @(posedge clk);
        #1 chk_outs("ext.e44", 3'b000, 1'b1, 8'd1);

        // Short rst_n glitch during RELEASE
        @(negedge clk);
        ext_rst_req = 1'b1;
        @(posedge clk);
        #1 chk("glitch.pre.restart_cnt", 32'(restart_cnt), 32'd2);
        @(negedge clk);
        ext_rst_req = 1'b0;
        repeat (18) @(posedge clk);
        #1 chk("glitch.pre.rst_out", 32'(rst_out), 32'(3'b110));
        #2 rst_n = 1'b0;
        #1 chk_outs("glitch.low", 3'b111, 1'b0, 8'd0);
        rst_n = 1'b1;
        run_seq("glitch");
        chk("glitch.restart_cnt", 32'(restart_cnt), 32'd0);

        // ext_rst_req in HOLD restarts the hold count without counting a restart
        reset_pulse();
        repeat (9) @(posedge clk);
        @(negedge clk);
        ext_rst_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ext_rst_req = 1'b0;
        repeat (15) @(posedge clk);
        #1 chk_outs("holdext.e25", 3'b111, 1'b0, 8'd0);
        @(posedge clk);
        #1 chk_outs("holdext.e26", 3'b110, 1'b0, 8'd0);

        // Late lock after power-up, with an ignored request in WAIT_LOCK
        @(negedge clk);
        pll_locked = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        ext_rst_req = 1'b1;
        @(negedge clk);
        ext_rst_req = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk_outs("latelock.wait", 3'b111, 1'b0, 8'd0);
        repeat (20) @(posedge clk);
        #1 chk_outs("latelock.wait2", 3'b111, 1'b0, 8'd0);
        repeat (14) @(negedge clk);
        pll_locked = 1'b1;
        run_seq("latelock");
        chk("latelock.restart_cnt", 32'(restart_cnt), 32'd0);

        // Lock loss and ext_rst_req seen on the same edge: lock loss wins
        @(negedge clk);
        pll_locked = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("both.e2.rst_out", 32'(rst_out), 32'(3'b000));
        @(negedge clk);
        ext_rst_req = 1'b1;
        @(posedge clk);
        #1 chk_outs("both.e3", 3'b111, 1'b0, 8'd1);
        @(negedge clk);
        ext_rst_req = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk_outs("both.hold", 3'b111, 1'b0, 8'd1);
        @(negedge clk);
        pll_locked = 1'b1;
        run_seq("both.relock");
        chk("both.restart_cnt", 32'(restart_cnt), 32'd1);

        // Saturation of restart_cnt
        reset_pulse();
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            n = 0;
            while (!seq_done && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("sat.%0d.seq_done", i), 32'(seq_done), 32'd1);
            @(negedge clk);
            ext_rst_req = 1'b1;
            @(posedge clk);
            #1;
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            chk($sformatf("sat.%0d.restart_cnt", i), 32'(restart_cnt), 32'(exp_cnt));
            @(negedge clk);
            ext_rst_req = 1'b0;
        end
        chk("sat.final", 32'(restart_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
